// File: rtl/biquad_coeff_loader_if.sv
// SPI pin bundle between the MCU (master) and the biquad coefficient loader (slave).
interface biquad_coeff_loader_if;
  logic sck;
  logic cs_n;
  logic sdi;
  logic sdo;

  modport master (output sck, output cs_n, output sdi, input sdo);
  modport slave  (input sck, input cs_n, input sdi, output sdo);
endinterface

// File: rtl/biquad_coeff_loader.sv
// SPI-slave loader for Q2.14 biquad coefficients: stages a five-word frame in a
// shadow bank and commits it to the filter only on a sample strobe.
//
// state    | meaning
// ST_IDLE  | cs_n high; waiting for a synchronized cs fall
// ST_SHIFT | cs_n low; sdi shifted in on sck rise, readback shifted out on sck fall
module biquad_coeff_loader #(
  parameter int                         COEFF_W   = 16,
  parameter int                         NUM_COEFF = 5,
  parameter logic signed [COEFF_W-1:0]  RESET_B0  = 16'sd16384
) (
  input  logic                       clk,
  input  logic                       reset,
  biquad_coeff_loader_if.slave       spi,
  input  logic                       sample_strobe,
  output logic signed [COEFF_W-1:0]  b0,
  output logic signed [COEFF_W-1:0]  b1,
  output logic signed [COEFF_W-1:0]  b2,
  output logic signed [COEFF_W-1:0]  a1,
  output logic signed [COEFF_W-1:0]  a2,
  output logic                       coeff_pending,
  output logic                       update_pulse,
  output logic                       frame_err
);

  localparam int             FRAME_W    = COEFF_W * NUM_COEFF;
  localparam logic [6:0]     FRAME_BITS = 7'(FRAME_W);
  localparam logic [6:0]     CNT_MAX    = 7'd127;
  localparam logic [FRAME_W-1:0] RESET_BANK =
    {RESET_B0, {(FRAME_W-COEFF_W){1'b0}}};

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  state_t             state;
  state_t             state_nxt;

  logic [2:0]         sck_sr;
  logic [2:0]         cs_sr;
  logic [1:0]         sdi_sr;
  logic               sck_rise;
  logic               sck_fall;
  logic               cs_fall;
  logic               cs_rise;

  logic               frame_start;
  logic               frame_end;
  logic               shift_in;
  logic               shift_out;
  logic               frame_good;
  logic               commit;

  logic [6:0]         bit_cnt;
  logic [FRAME_W-1:0] rx_sr;
  logic [FRAME_W-1:0] rb_sr;
  logic [FRAME_W-1:0] shadow;

  // cs_n synchronizer resets low so that a cs_n already low when reset is
  // released is not mistaken for a fall; a frame starts only after cs is seen high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sck_sr <= '0;
      cs_sr  <= '0;
      sdi_sr <= '0;
    end else begin
      sck_sr <= {sck_sr[1:0], spi.sck};
      cs_sr  <= {cs_sr[1:0], spi.cs_n};
      sdi_sr <= {sdi_sr[0], spi.sdi};
    end
  end

  assign sck_rise =  sck_sr[1] & ~sck_sr[2];
  assign sck_fall = ~sck_sr[1] &  sck_sr[2];
  assign cs_fall  = ~cs_sr[1]  &  cs_sr[2];
  assign cs_rise  =  cs_sr[1]  & ~cs_sr[2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    shift_in    = 1'b0;
    shift_out   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cs_fall) begin
          state_nxt   = ST_SHIFT;
          frame_start = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (cs_rise) begin
          state_nxt = ST_IDLE;
          frame_end = 1'b1;
        end else begin
          shift_in  = sck_rise;
          shift_out = sck_fall;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign frame_good = frame_end && (bit_cnt == FRAME_BITS);
  assign commit     = sample_strobe && coeff_pending;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt <= '0;
      rx_sr   <= '0;
    end else begin
      if (frame_start) begin
        bit_cnt <= '0;
      end else if (shift_in && (bit_cnt != CNT_MAX)) begin
        bit_cnt <= bit_cnt + 7'd1;
      end
      if (shift_in) begin
        rx_sr <= {rx_sr[FRAME_W-2:0], sdi_sr[1]};
      end
    end
  end

  // Readback holds the active set; clearing it at frame end keeps sdo low while cs is high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rb_sr <= '0;
    end else if (frame_start) begin
      rb_sr <= {b0, b1, b2, a1, a2};
    end else if (frame_end) begin
      rb_sr <= '0;
    end else if (shift_out) begin
      rb_sr <= {rb_sr[FRAME_W-2:0], 1'b0};
    end
  end

  assign spi.sdo = rb_sr[FRAME_W-1];

  // A commit reads the shadow before a same-edge good frame overwrites it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      b0            <= RESET_B0;
      b1            <= '0;
      b2            <= '0;
      a1            <= '0;
      a2            <= '0;
      shadow        <= RESET_BANK;
      coeff_pending <= 1'b0;
      frame_err     <= 1'b0;
      update_pulse  <= 1'b0;
    end else begin
      update_pulse <= commit;
      if (commit) begin
        b0 <= $signed(shadow[4*COEFF_W +: COEFF_W]);
        b1 <= $signed(shadow[3*COEFF_W +: COEFF_W]);
        b2 <= $signed(shadow[2*COEFF_W +: COEFF_W]);
        a1 <= $signed(shadow[1*COEFF_W +: COEFF_W]);
        a2 <= $signed(shadow[0*COEFF_W +: COEFF_W]);
      end
      if (frame_good) begin
        shadow        <= rx_sr;
        coeff_pending <= 1'b1;
        frame_err     <= 1'b0;
      end else begin
        if (commit) begin
          coeff_pending <= 1'b0;
        end
        if (frame_end) begin
          frame_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_biquad_coeff_loader.sv
// Scoreboard bench for biquad_coeff_loader: SPI frames and strobes drive a
// coefficient-bank model; commits are checked by a monitor on update_pulse.
module tb_biquad_coeff_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        sample_strobe;
  logic signed [15:0] b0, b1, b2, a1, a2;
  logic        coeff_pending;
  logic        update_pulse;
  logic        frame_err;

  biquad_coeff_loader_if spi ();

  biquad_coeff_loader dut (
    .clk           (clk),
    .reset         (reset),
    .spi           (spi),
    .sample_strobe (sample_strobe),
    .b0            (b0),
    .b1            (b1),
    .b2            (b2),
    .a1            (a1),
    .a2            (a2),
    .coeff_pending (coeff_pending),
    .update_pulse  (update_pulse),
    .frame_err     (frame_err)
  );

  always #5 clk = ~clk;

  // Model: active bank, shadow bank, pending and error flags.
  localparam logic [79:0] RESET_SET = {16'd16384, 64'd0};
  logic [79:0] m_active;
  logic [79:0] m_shadow;
  logic        m_pending;
  logic        m_err;
  logic [79:0] exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic        prev_pulse = 1'b0;

  function automatic logic [79:0] outs();
    return {b0, b1, b2, a1, a2};
  endfunction

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  function automatic void m_reset();
    m_active  = RESET_SET;
    m_shadow  = RESET_SET;
    m_pending = 1'b0;
    m_err     = 1'b0;
  endfunction

  function automatic void m_strobe();
    if (m_pending) begin
      exp_q.push_back(m_shadow);
      m_active  = m_shadow;
      m_pending = 1'b0;
    end
  endfunction

  function automatic void m_frame_end(input logic [79:0] data, input int nbits);
    if (nbits == 80) begin
      m_shadow  = data;
      m_pending = 1'b1;
      m_err     = 1'b0;
    end else begin
      m_err = 1'b1;
    end
  endfunction

  // Monitor: every update_pulse must match a queued commit and last one cycle.
  always @(negedge clk) begin
    if (reset && update_pulse) begin
      chk1("update_pulse_width", prev_pulse, 1'b0);
      if (exp_q.size() == 0) begin
        failures++;
        checks++;
        $display("FAIL unexpected_update_pulse actual=1 required=0 outputs=%h", outs());
      end else begin
        chk("commit_values", outs(), exp_q.pop_front());
      end
    end
    prev_pulse = update_pulse;
  end

  task automatic check_state(input string name);
    chk({name, "_outputs"}, outs(), m_active);
    chk1({name, "_pending"}, coeff_pending, m_pending);
    chk1({name, "_frame_err"}, frame_err, m_err);
  endtask

  task automatic sck_bit(input logic d, output logic q);
    spi.sdi = d;
    repeat (4) @(negedge clk);
    q = spi.sdo;
    spi.sck = 1'b1;
    repeat (4) @(negedge clk);
    spi.sck = 1'b0;
  endtask

  task automatic strobe();
    @(negedge clk);
    sample_strobe = 1'b1;
    m_strobe();
    @(negedge clk);
    sample_strobe = 1'b0;
    repeat (3) @(negedge clk);
    chk("commit_seen", 80'(exp_q.size()), 80'd0);
    check_state("after_strobe");
  endtask

  task automatic spi_frame(input logic [79:0] data, input int nbits, input bit collide,
                           output logic [79:0] rd);
    logic [79:0] exp_rb;
    logic        q;
    exp_rb = m_active;
    rd     = '0;
    @(negedge clk);
    spi.cs_n = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      sck_bit((i < 80) ? data[79-i] : 1'b0, q);
      if (i < 80) rd[79-i] = q;
    end
    repeat (6) @(negedge clk);
    spi.cs_n = 1'b1;
    if (collide) begin
      // strobe lands on the edge where the frame end is acted on
      repeat (2) @(negedge clk);
      sample_strobe = 1'b1;
      m_strobe();
      @(negedge clk);
      sample_strobe = 1'b0;
    end
    m_frame_end(data, nbits);
    repeat (6) @(negedge clk);
    chk1("sdo_idle", spi.sdo, 1'b0);
    if (nbits >= 80) chk("readback", rd, exp_rb);
    chk("commit_seen", 80'(exp_q.size()), 80'd0);
    check_state("frame");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [79:0] rd;
    logic [79:0] d;
    logic        q;
    int          nb;
    int          sel;

    reset = 1'b0;
    spi.sck = 1'b0;
    spi.cs_n = 1'b1;
    spi.sdi = 1'b0;
    sample_strobe = 1'b0;
    m_reset();
    repeat (3) @(negedge clk);
    chk("reset_outputs", outs(), RESET_SET);
    chk1("reset_sdo", spi.sdo, 1'b0);
    chk1("reset_pending", coeff_pending, 1'b0);
    chk1("reset_update", update_pulse, 1'b0);
    chk1("reset_err", frame_err, 1'b0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    repeat (3) strobe();

    // full write, pending before commit, then commit
    spi_frame({16'd8192, 16'd8192, 16'd0, 16'hC666, 16'd0}, 80, 1'b0, rd);
    chk1("full_pending", coeff_pending, 1'b1);
    chk("full_unchanged", outs(), RESET_SET);
    strobe();
    chk("full_committed", outs(), {16'd8192, 16'd8192, 16'd0, 16'hC666, 16'd0});

    // short frame then good frame
    spi_frame({16'd1, 16'd2, 16'd3, 16'd4, 16'd5}, 79, 1'b0, rd);
    chk1("short_err", frame_err, 1'b1);
    spi_frame({16'd1, 16'd2, 16'd3, 16'd4, 16'd5}, 80, 1'b0, rd);
    chk1("good_clears_err", frame_err, 1'b0);
    strobe();

    // overwrite: latest frame wins
    spi_frame({16'd1000, 16'd11, 16'd12, 16'd13, 16'd14}, 80, 1'b0, rd);
    spi_frame({16'd2000, 16'd21, 16'd22, 16'd23, 16'd24}, 80, 1'b0, rd);
    strobe();
    chk("overwrite_b0", 80'(b0), 80'd2000);

    // strobe coincides with frame end: no commit until next strobe
    spi_frame({16'h4000, 16'h0000, 16'h0000, 16'hC666, 16'h1234}, 80, 1'b1, rd);
    chk1("collide_still_pending", coeff_pending, 1'b1);
    strobe();

    // readback of the active set
    d = 80'({$urandom(), $urandom(), $urandom()});
    spi_frame(d, 80, 1'b0, rd);
    chk("readback_stream", rd, 80'h4000_0000_0000_C666_1234);
    strobe();

    // randomized frames, lengths, strobes and collisions
    for (int it = 0; it < 14; it++) begin
      sel = $urandom_range(0, 6);
      case (sel)
        0: nb = 79;
        1: nb = 81;
        2: nb = 0;
        3: nb = $urandom_range(1, 78);
        default: nb = 80;
      endcase
      d = 80'({$urandom(), $urandom(), $urandom()});
      spi_frame(d, nb, ($urandom_range(0, 2) == 0), rd);
      if ($urandom_range(0, 1) == 1) strobe();
    end

    // reset mid-frame aborts with no error; the in-flight frame is ignored
    spi_frame({16'd7, 16'd8, 16'd9, 16'd10, 16'd11}, 79, 1'b0, rd);
    @(negedge clk);
    spi.cs_n = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 20; i++) sck_bit(1'b1, q);
    reset = 1'b0;
    m_reset();
    exp_q.delete();
    @(negedge clk);
    chk("midreset_outputs", outs(), RESET_SET);
    chk1("midreset_err", frame_err, 1'b0);
    chk1("midreset_sdo", spi.sdo, 1'b0);
    reset = 1'b1;
    for (int i = 0; i < 60; i++) sck_bit(1'b0, q);
    repeat (6) @(negedge clk);
    spi.cs_n = 1'b1;
    repeat (8) @(negedge clk);
    check_state("after_inflight");
    spi_frame({16'd300, 16'd301, 16'd302, 16'd303, 16'd304}, 80, 1'b0, rd);
    strobe();

    repeat (10) @(negedge clk);
    chk("final_queue_empty", 80'(exp_q.size()), 80'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/biquad_coeff_loader.md
# biquad_coeff_loader

SPI-slave writer that delivers Q2.14 biquad coefficients from the MCU to `iir_filter`. It receives a five-coefficient frame over SPI mode 0 and stages it in a shadow bank. It commits the whole bank to the filter's `b0/b1/b2/a1/a2` inputs only on a sample boundary, so the filter never runs on a mixed old/new coefficient set. It also shifts the active set back out on `sdo` for MCU readback.

## Interface
- `COEFF_W`, 16, coefficient width, signed Q2.14.
- `NUM_COEFF`, 5, coefficients per frame; wire order is b0, b1, b2, a1, a2.
- `RESET_B0`, 16'sd16384, reset and power-up value of `b0` (1.0, unity passthrough).

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `sck`  in  1  SPI clock from MCU, asynchronous to `clk`, idle low.
- `cs_n`  in  1  SPI chip select, active low, asynchronous.
- `sdi`  in  1  SPI data in (MOSI), asynchronous.
- `sdo`  out  1  SPI data out (MISO), readback of the active coefficients.
- `sample_strobe`  in  1  one-cycle pulse per audio sample; this is the only point at which a commit may occur.
- `b0`, `b1`, `b2`, `a1`, `a2`  out  16 each, signed  active coefficients driven to `iir_filter`.
- `coeff_pending`  out  1  a valid frame is staged and waiting for a strobe.
- `update_pulse`  out  1  one-cycle pulse in the cycle after a commit.
- `frame_err`  out  1  sticky; set by a malformed frame, cleared by the next good frame.

## Operation
- **Input synchronisation.**
  - `sck`, `cs_n` and `sdi` each pass through a 2-FF synchronizer.
  - A third flop provides edge detection: sck rise, sck fall, cs fall, cs rise.
  - Everything downstream uses only these synchronized signals.
- **Frame start (cs fall).**
  - Clear the 7-bit bit counter.
  - Load the 80-bit readback register with the active set {b0,b1,b2,a1,a2}, MSB first.
- **sck rise while cs is low.**
  - Shift the synchronized `sdi` into the 80-bit receive register, LSB end; the first bit received ends up as b0[15].
  - Increment the bit counter, saturating at 127.
- **sck fall while cs is low.**
  - Shift the readback register left.
  - `sdo` always equals the readback register MSB, so bit 79 is presented before the first sck rise.
  - `sdo` = 0 while cs is high.
- **Frame end (cs rise).**
  - Bit count exactly 80: copy the receive register into the shadow bank, set `coeff_pending`, clear `frame_err`.
  - Any other count, including 0: the shadow bank is untouched, `coeff_pending` is unchanged, and `frame_err` is set.
- **Overwrite.** A good frame that completes while `coeff_pending` = 1 overwrites the shadow bank. The latest frame wins; nothing is queued.
- **Commit.**
  - Occurs on a clock edge where `sample_strobe` = 1 and `coeff_pending` = 1 (both registered state).
  - The shadow bank is copied to the outputs and `coeff_pending` is cleared.
  - `update_pulse` = 1 on the following cycle only.
- **State machine.**
  - States: IDLE (cs high), SHIFT (cs low).
  - Transitions happen on synchronized cs fall and cs rise.
  - Commit logic is independent of this FSM.
- **Arithmetic.** None is performed; bits are passed through verbatim. There is no saturation or reformatting.

## Timing
- **Reset values.**
  - `b0` = RESET_B0; `b1`, `b2`, `a1`, `a2` = 0.
  - Shadow bank equals the output reset values.
  - `coeff_pending` = 0, `update_pulse` = 0, `frame_err` = 0, `sdo` = 0.
  - FSM = IDLE, bit counter = 0.
- **Synchronizer latency.** An SPI pin edge is acted on 3 `clk` edges later.
- **Clock ratio.** `sck` high and low phases must each be ≥ 4 `clk` periods; cs setup and hold to `sck` must also be ≥ 4 `clk` periods. Behaviour outside these limits is undefined.
- **Commit latency.** From the clock edge that sets `coeff_pending` to the first `sample_strobe` edge thereafter, outputs change on that strobe edge.
- **Simultaneous events.**
  - Frame end and strobe on the same edge: `coeff_pending` is still 0 when the strobe is sampled, so the commit occurs on the next strobe.
  - Commit and a new frame end on the same edge: the commit uses the old shadow contents. The new frame then loads the shadow and `coeff_pending` stays 1.
- **Readback during a pending update.** The readback register captures the active set, not the shadow set.
- **Reset mid-frame.** An assertion during SHIFT aborts the frame and returns every register to its reset value; no error is flagged. Bits of a frame already in flight at deassertion are counted only from the next cs fall.
- **Outputs.** All outputs are registered and change only on the rising edge of `clk` or on `reset` assertion.

## Test plan
- **Reset.** Assert `reset` = 0 → `b0` = 16384, others 0, `sdo` = 0, all flags 0. Deassert, then strobe 3× → no output change, `update_pulse` never 1.
- **Full write and commit.**
  - Stimulus: 80-bit frame with b0 = 8192, b1 = 8192, b2 = 0, a1 = -14746 (0xC666), a2 = 0; `sck` = clk/8.
  - After cs rise: `coeff_pending` = 1 and outputs unchanged.
  - Next strobe: all five outputs take the new values, `coeff_pending` = 0, and `update_pulse` is high for exactly 1 cycle.
- **Short frame.** Send 79 bits and raise cs → `frame_err` = 1, `coeff_pending` unchanged, outputs unchanged. A following good frame clears `frame_err`.
- **Overwrite.** Send frame A (b0 = 1000), then frame B (b0 = 2000) with no strobe in between, then strobe → b0 = 2000; a single `update_pulse`.
- **Strobe/frame-end collision.** Align cs rise so the pending-set edge coincides with `sample_strobe` → no commit on that edge; the commit happens on the next strobe.
- **Readback.** After committing 0x4000, 0x0000, 0x0000, 0xC666, 0x1234, run a frame with any `sdi` and capture `sdo` on sck rises → the captured stream is 0x4000_0000_0000_C666_1234.
